uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Detects the start-bit falling edge and runs the per-bit edge counter and the frame bit counter.
- Pulses the enables of the data sampler, start checker, deserializer, parity checker and stop checker, then consumes their error flags.
- Issues a one-cycle data_valid for each clean frame; sits between the rx pin synchronizer and the RX datapath checkers.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..8).
- PRESC_W, 6, width of the prescale input and of the edge counter.

Ports:
- clk  input  1  RX oversampling clock.
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  synchronized serial line, idle high.
- prescale  input  PRESC_W  oversampling ratio P; legal values 8, 16, 32; sampled only in IDLE.
- par_en  input  1  frame carries a parity bit.
- strt_glitch  input  1  start checker result, 1 = false start.
- par_err  input  1  parity checker result.
- stp_err  input  1  stop checker result.
- edge_cnt  output  PRESC_W  oversample edge index within the current bit, 0..P-1.
- bit_cnt  output  4  frame bit index: 0 = start, 1..DATA_WIDTH = data, then parity (if enabled), then stop.
- dat_samp_en  output  1  sampler enable, high in every non-IDLE state.
- strt_chk_en  output  1  one-cycle pulse.
- deser_en  output  1  one-cycle pulse.
- par_chk_en  output  1  one-cycle pulse.
- stp_chk_en  output  1  one-cycle pulse.
- data_valid  output  1  one-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; edge_cnt=0, bit_cnt=0; all enables and data_valid = 0.
- Prescale latch: P is latched into an internal register on the IDLE->START transition. A prescale change mid-frame has no effect.
- Sample point: S = P/2+2. The sampler's majority bit is stable from edge P/2+2 onward.
- Check pulse timing: each checker enable pulses for exactly one cycle when edge_cnt==S in its state. Checker outputs are registered, so the FSM reads them at edge_cnt==P-1.
- Edge counter: increments every cycle outside IDLE and wraps P-1 -> 0.
- Bit counter: increments on the wrap. Both counters clear on entry to IDLE.
- IDLE: rx_in==0 -> START, with edge_cnt=0 on the first START cycle.
- START: strt_chk_en at S. At edge P-1:
  - strt_glitch=1 -> IDLE (no data_valid, no further pulses).
  - strt_glitch=0 -> DATA.
- DATA: deser_en at S of each data bit (DATA_WIDTH pulses total). At edge P-1 of the last data bit: -> PARITY if par_en, else STOP.
- PARITY: par_chk_en at S. -> STOP at edge P-1. Parity errors do not abort the frame.
- STOP: stp_chk_en at S. At edge P-1:
  - data_valid = !(par_err|stp_err) for one cycle, where par_err is forced to 0 when par_en=0.
  - Next state: rx_in==0 -> START (back-to-back frame, counters restart at 0); else -> IDLE.
- Enable coupling: at most one checker/deser enable is high in any cycle.
- par_en: latched with prescale; a mid-frame change is ignored.
- Reset mid-frame: immediate return to IDLE with all outputs cleared; no data_valid for the partial frame.
- Unsupported prescale (not 8/16/32): behaviour undefined; a simulation assertion flags it.

Decomposition:
- Shared package: rx_state_t enum {IDLE, START, DATA, PARITY, STOP}, encoded in 3 bits. It is reused by the RX top and the verification monitors.
- Sub-module uart_rx_edge_bit_cnt: edge and bit counters with wrap at P-1, enabled by the FSM, cleared on IDLE. The FSM stays in uart_rx_ctrl.

Test Plan:
- Clean 8N1 frame, P=8, data 0xA5:
  - deser_en pulses 8 times, each at edge_cnt=6.
  - data_valid=1 one cycle, 80 cycles after the start edge.
  - Return to IDLE.
- 8E1 frame, P=16, parity correct:
  - par_chk_en pulses once, at bit_cnt=9, edge 10.
  - data_valid after 176 cycles.
- Same frame with par_err=1: no data_valid; state returns to IDLE.
- False start: rx_in low for 3 cycles, P=16, strt_glitch=1 at edge 15:
  - No deser_en pulses.
  - IDLE at cycle 16.
- Back-to-back frames, P=32, rx_in low at the stop bit's edge 31:
  - START entered directly with no IDLE cycle.
  - Two data_valid pulses.
- rst asserted at bit_cnt=4 of a frame:
  - All outputs 0 asynchronously, with no data_valid.
  - The next frame after rst release is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART RX control path.
// Used by the RX sequencer, its counter block and verification monitors.
package uart_rx_ctrl_pkg;

  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Oversample edge at which the sampler's majority bit has settled.
  function automatic int unsigned sample_edge(input int unsigned p);
    return (p >> 1) + 32'd2;
  endfunction

  function automatic logic prescale_legal(input int unsigned p);
    return (p == 32'd8) || (p == 32'd16) || (p == 32'd32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit oversample edge counter and frame bit counter.
// The edge counter wraps at edge_max and carries into the bit counter.
module uart_rx_edge_bit_cnt
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  input  logic [PRESC_W-1:0]   edge_max,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 edge_last_c
);

  logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign edge_last_c = (edge_cnt_q == edge_max);

  // Clear dominates; otherwise count and carry into the bit index on wrap.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (cnt_clr) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (cnt_en) begin
      if (edge_last_c) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: start detection, bit timing, checker enables and
// the per-frame data_valid pulse.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic                 par_en,
  input  logic                 strt_glitch,
  input  logic                 par_err,
  input  logic                 stp_err,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 dat_samp_en,
  output logic                 strt_chk_en,
  output logic                 deser_en,
  output logic                 par_chk_en,
  output logic                 stp_chk_en,
  output logic                 data_valid
);

  rx_state_t          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d;
  logic               dat_samp_en_q, dat_samp_en_d;
  logic               strt_chk_en_q, strt_chk_en_d;
  logic               deser_en_q, deser_en_d;
  logic               par_chk_en_q, par_chk_en_d;
  logic               stp_chk_en_q, stp_chk_en_d;
  logic               data_valid_q, data_valid_d;

  logic               cnt_en;
  logic               cnt_clr;
  logic               edge_last;
  logic [PRESC_W-1:0] edge_max;
  logic [PRESC_W-1:0] samp_m1;
  logic               pre_samp;
  logic               last_data_bit;

  assign edge_max      = presc_q - PRESC_W'(1);
  assign samp_m1       = PRESC_W'(sample_edge(32'(presc_q)) - 32'd1);
  assign cnt_en        = (state_q != IDLE);
  // Enables are registered, so decode one edge early to land on the sample edge.
  assign pre_samp      = (edge_cnt == samp_m1);
  assign last_data_bit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .edge_max    (edge_max),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .edge_last_c (edge_last)
  );

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    cnt_clr      = 1'b0;
    data_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d  = START;
          presc_d  = prescale;
          par_en_d = par_en;
        end
      end
      START: begin
        if (edge_last) state_d = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (edge_last && last_data_bit) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (edge_last) state_d = STOP;
      end
      STOP: begin
        if (edge_last) begin
          data_valid_d = !((par_en_q & par_err) | stp_err);
          // A low line at the end of the stop bit is the next start bit.
          if (!rx_in) begin
            state_d  = START;
            presc_d  = prescale;
            par_en_d = par_en;
            cnt_clr  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) cnt_clr = 1'b1;

    dat_samp_en_d = (state_d != IDLE);
    strt_chk_en_d = (state_q == START)  && pre_samp;
    deser_en_d    = (state_q == DATA)   && pre_samp;
    par_chk_en_d  = (state_q == PARITY) && pre_samp;
    stp_chk_en_d  = (state_q == STOP)   && pre_samp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      presc_q       <= PRESC_W'(8);
      par_en_q      <= 1'b0;
      dat_samp_en_q <= 1'b0;
      strt_chk_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      par_en_q      <= par_en_d;
      dat_samp_en_q <= dat_samp_en_d;
      strt_chk_en_q <= strt_chk_en_d;
      deser_en_q    <= deser_en_d;
      par_chk_en_q  <= par_chk_en_d;
      stp_chk_en_q  <= stp_chk_en_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign dat_samp_en = dat_samp_en_q;
  assign strt_chk_en = strt_chk_en_q;
  assign deser_en    = deser_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stp_chk_en  = stp_chk_en_q;
  assign data_valid  = data_valid_q;

  // Flag an oversampling ratio the bit timing was not built for.
  a_prescale_legal : assert property (@(posedge clk) disable iff (!rst)
    (((state_q == IDLE) || ((state_q == STOP) && edge_last)) && !rx_in)
      |-> prescale_legal(32'(prescale)))
    else $error("uart_rx_ctrl: unsupported prescale %0d", prescale);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame-timing reference model,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk         = 1'b0;
  logic          rst         = 1'b0;
  logic          rx_in       = 1'b1;
  logic [PW-1:0] prescale    = PW'(8);
  logic          par_en      = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err     = 1'b0;
  logic          stp_err     = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
  logic [15:0]   dut_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  assign dut_v = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
                  par_chk_en, stp_chk_en, data_valid};

  function automatic int frame_bits(input bit pe);
    return DW + 2 + (pe ? 1 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a frame is a cycle offset from START entry.
  bit m_act = 1'b0;
  int m_off = 0;
  int m_p   = 8;
  bit m_par = 1'b0;
  bit m_dv  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 1'b0;
      m_off = 0;
      m_dv  = 1'b0;
    end else if (!m_act) begin
      m_dv = 1'b0;
      if (!rx_in) begin
        m_act = 1'b1;
        m_off = 0;
        m_p   = int'(prescale);
        m_par = par_en;
      end
    end else begin
      m_dv = 1'b0;
      if (m_off % m_p != m_p - 1) m_off++;
      else if (m_off / m_p == 0 && strt_glitch) m_act = 1'b0;
      else if (m_off / m_p == frame_bits(m_par) - 1) begin
        m_dv = !((m_par && par_err) || stp_err);
        if (!rx_in) begin
          m_off = 0;
          m_p   = int'(prescale);
          m_par = par_en;
        end else begin
          m_act = 1'b0;
        end
      end else m_off++;
    end
  end

  // Every cycle out of reset the whole output vector must match the model.
  always @(negedge clk) begin
    int e, b, s, nb;
    logic [15:0] exp_v;
    if (rst) begin
      exp_v = '0;
      if (m_act) begin
        e  = m_off % m_p;
        b  = m_off / m_p;
        s  = m_p / 2 + 2;
        nb = frame_bits(m_par);
        exp_v[15:10] = PW'(e);
        exp_v[9:6]   = 4'(b);
        exp_v[5]     = 1'b1;
        exp_v[4]     = (b == 0 && e == s);
        exp_v[3]     = (b >= 1 && b <= DW && e == s);
        exp_v[2]     = (m_par && b == DW + 1 && e == s);
        exp_v[1]     = (b == nb - 1 && e == s);
      end
      exp_v[0] = m_dv;
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t dut=%h model=%h", $time, dut_v, exp_v);
      end
    end
  end

  int o_dv_n, o_dv_c, o_des_n, o_des_bad, o_par_n, o_par_b, o_par_e, o_idle_c;

  // Drive one frame from IDLE and record pulse timing relative to START entry.
  task automatic run_frame(input int p, input bit pe, input bit glitch, input bit perr,
                           input bit serr, input int low_cycles, input bit b2b,
                           input bit chg, input int win);
    bit b2b_done;
    int s;
    b2b_done = 1'b0;
    s        = p / 2 + 2;
    o_dv_n = 0; o_dv_c = -1; o_des_n = 0; o_des_bad = 0;
    o_par_n = 0; o_par_b = -1; o_par_e = -1; o_idle_c = -1;
    @(negedge clk);
    prescale = PW'(p); par_en = pe; strt_glitch = glitch;
    par_err = perr; stp_err = serr; rx_in = 1'b0;
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      if (c + 1 >= low_cycles) rx_in = 1'b1;
      if (b2b && !b2b_done && m_act && m_off == frame_bits(pe) * p - 1) begin
        rx_in    = 1'b0;
        b2b_done = 1'b1;
      end
      if (chg && c == 20) begin
        prescale = PW'(32);
        par_en   = ~pe;
      end
      if (data_valid) begin
        o_dv_n++;
        if (o_dv_c < 0) o_dv_c = c;
      end
      if (deser_en) begin
        o_des_n++;
        if (int'(edge_cnt) != s) o_des_bad++;
      end
      if (par_chk_en) begin
        o_par_n++;
        o_par_b = int'(bit_cnt);
        o_par_e = int'(edge_cnt);
      end
      if (!dat_samp_en && o_idle_c < 0) o_idle_c = c;
    end
    prescale = PW'(p); par_en = pe; strt_glitch = 1'b0;
    par_err = 1'b0; stp_err = 1'b0; rx_in = 1'b1;
  endtask

  initial begin
    int found;
    int rnd_dv;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(dut_v), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, P=8 (payload 0xA5 does not affect sequencing)
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 100);
    chk("8n1_deser_count", o_des_n, 8);
    chk("8n1_deser_edge_bad", o_des_bad, 0);
    chk("8n1_par_count", o_par_n, 0);
    chk("8n1_dv_count", o_dv_n, 1);
    chk("8n1_dv_latency", o_dv_c, 80);
    chk("8n1_idle_cycle", o_idle_c, 80);

    // 8E1, P=16, clean parity
    run_frame(16, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 200);
    chk("8e1_par_count", o_par_n, 1);
    chk("8e1_par_bit", o_par_b, 9);
    chk("8e1_par_edge", o_par_e, 10);
    chk("8e1_dv_count", o_dv_n, 1);
    chk("8e1_dv_latency", o_dv_c, 176);

    // 8E1, P=16, parity error
    run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 200);
    chk("8e1_perr_dv_count", o_dv_n, 0);
    chk("8e1_perr_idle_cycle", o_idle_c, 176);

    // false start
    run_frame(16, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 40);
    chk("glitch_deser_count", o_des_n, 0);
    chk("glitch_idle_cycle", o_idle_c, 16);
    chk("glitch_dv_count", o_dv_n, 0);

    // back-to-back frames, P=32
    run_frame(32, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 680);
    chk("b2b_dv_count", o_dv_n, 2);
    chk("b2b_first_dv", o_dv_c, 320);
    chk("b2b_first_idle", o_idle_c, 640);

    // stop error drops the frame
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 100);
    chk("stperr_dv_count", o_dv_n, 0);

    // parity error ignored without parity
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 100);
    chk("nopar_perr_dv_count", o_dv_n, 1);

    // prescale and par_en changes mid-frame are ignored
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 100);
    chk("midchg_dv_latency", o_dv_c, 80);
    chk("midchg_par_count", o_par_n, 0);

    // asynchronous reset at bit 4
    @(negedge clk);
    prescale = PW'(16); par_en = 1'b0; rx_in = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      rx_in = 1'b1;
      if (m_act && m_off == 4 * 16 + 5) found = 1;
    end
    chk("rst_reached_bit4", found, 1);
    chk("rst_pre_bit_cnt", 32'(bit_cnt), 32'd4);
    #2 rst = 1'b0;
    #1 chk("rst_async_outputs", 32'(dut_v), 32'd0);
    @(negedge clk);
    chk("rst_held_outputs", 32'(dut_v), 32'd0);
    rst = 1'b1;
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 200);
    chk("post_rst_dv_count", o_dv_n, 1);
    chk("post_rst_dv_latency", o_dv_c, 160);

    // randomized traffic checked by the per-cycle model comparison
    rnd_dv = 0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (!m_act && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       prescale = PW'(8);
          1:       prescale = PW'(16);
          default: prescale = PW'(32);
        endcase
        par_en = 1'($urandom_range(0, 1));
      end
      rx_in       = ($urandom_range(0, 3) != 0);
      strt_glitch = ($urandom_range(0, 7) == 0);
      par_err     = ($urandom_range(0, 3) == 0);
      stp_err     = ($urandom_range(0, 7) == 0);
      if (data_valid) rnd_dv++;
    end
    chk("random_dv_seen", 32'(rnd_dv > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
